// File: rtl/mod_counter_ctrl.sv
// Programmable mod-N counter sequencer: one-shot or continuous runs, with a
// terminal-count strobe on each wrap and a completion pulse after N wraps.
module mod_counter_ctrl #(
   parameter int WIDTH  = 4,
   parameter int WRAP_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic              hold_i,
   input  logic              cont_i,
   input  logic [WIDTH-1:0]  mod_i,
   input  logic [WRAP_W-1:0] wraps_i,
   output logic [WIDTH-1:0]  count_o,
   output logic              tc_o,
   output logic [WRAP_W-1:0] wrap_cnt_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  count_q, count_d;
   logic [WRAP_W-1:0] wrap_q, wrap_d;
   logic [WIDTH-1:0]  mod_q, mod_d;
   logic [WRAP_W-1:0] wraps_q, wraps_d;
   logic              cont_q, cont_d;
   logic              err_q, err_d;
   logic              tc;
   logic              cfg_ok;
   logic              at_top;

   assign cfg_ok = (mod_i >= WIDTH'(2)) && (cont_i || (wraps_i != '0));
   assign at_top = (count_q == mod_q - 1'b1);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      wrap_d  = wrap_q;
      mod_d   = mod_q;
      wraps_d = wraps_q;
      cont_d  = cont_q;
      err_d   = 1'b0;
      tc      = 1'b0;
      // Abort overrides everything, including a wrap landing in the same cycle.
      if (stop_i) begin
         state_d = S_IDLE;
         count_d = '0;
         wrap_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  if (cfg_ok) begin
                     mod_d   = mod_i;
                     wraps_d = wraps_i;
                     cont_d  = cont_i;
                     count_d = '0;
                     wrap_d  = '0;
                     state_d = S_RUN;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (!hold_i) begin
                  if (at_top) begin
                     tc      = 1'b1;
                     count_d = '0;
                     if (!cont_q && (wrap_q == wraps_q - 1'b1)) begin
                        wrap_d  = wraps_q;
                        state_d = S_DONE;
                     end else begin
                        wrap_d = wrap_q + 1'b1;
                     end
                  end else begin
                     count_d = count_q + 1'b1;
                  end
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         count_q <= '0;
         wrap_q  <= '0;
         mod_q   <= '0;
         wraps_q <= '0;
         cont_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         wrap_q  <= wrap_d;
         mod_q   <= mod_d;
         wraps_q <= wraps_d;
         cont_q  <= cont_d;
         err_q   <= err_d;
      end
   end

   assign count_o    = count_q;
   assign wrap_cnt_o = wrap_q;
   assign tc_o       = tc;
   assign busy_o     = (state_q == S_RUN);
   assign done_o     = (state_q == S_DONE);
   assign err_o      = err_q;

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Directed bench for mod_counter_ctrl: inputs change and outputs are sampled
// on the falling edge, away from the rising edge the design uses.
module tb_mod_counter_ctrl;
   logic       clk_i = 1'b0;
   logic       rst_i, start_i, stop_i, hold_i, cont_i;
   logic [3:0] mod_i;
   logic [7:0] wraps_i;
   logic [3:0] count_o;
   logic       tc_o;
   logic [7:0] wrap_cnt_o;
   logic       busy_o, done_o, err_o;

   int total = 0;
   int bad   = 0;

   mod_counter_ctrl #(.WIDTH(4), .WRAP_W(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
      .hold_i(hold_i), .cont_i(cont_i), .mod_i(mod_i), .wraps_i(wraps_i),
      .count_o(count_o), .tc_o(tc_o), .wrap_cnt_o(wrap_cnt_o),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   // Observed vector layout: {count, tc, wrap_cnt, busy, done, err}
   task automatic chk(input string tag, input logic [3:0] cnt, input logic tc,
                      input logic [7:0] wc, input logic busy, input logic done,
                      input logic err);
      logic [15:0] obs, exp;
      #1;
      obs = {count_o, tc_o, wrap_cnt_o, busy_o, done_o, err_o};
      exp = {cnt, tc, wc, busy, done, err};
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed cnt=%0d tc=%0b wc=%0d busy=%0b done=%0b err=%0b expected cnt=%0d tc=%0b wc=%0d busy=%0b done=%0b err=%0b",
                tag, obs[15:12], obs[11], obs[10:3], obs[2], obs[1], obs[0],
                cnt, tc, wc, busy, done, err);
      end
   endtask

   task automatic start_cfg(input logic c, input logic [3:0] m, input logic [7:0] w);
      start_i = 1'b1; cont_i = c; mod_i = m; wraps_i = w;
      tick();
      start_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; hold_i = 1'b0;
      cont_i = 1'b0; mod_i = '0; wraps_i = '0;
      @(negedge clk_i);
      tick();
      tick();
      chk("reset", 0, 0, 0, 0, 0, 0);
      rst_i = 1'b0;
      tick();
      chk("idle_after_reset", 0, 0, 0, 0, 0, 0);

      // One-shot mod 10, two wraps; config inputs changed mid-run must not matter
      start_cfg(1'b0, 4'd10, 8'd2);
      mod_i = 4'd3; wraps_i = 8'd1; cont_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         chk($sformatf("oneshot_c%0d", i), 4'(i % 10), (i % 10) == 9, 8'(i / 10), 1, 0, 0);
         tick();
      end
      chk("oneshot_done", 0, 0, 2, 0, 1, 0);
      tick();
      chk("oneshot_idle", 0, 0, 2, 0, 0, 0);

      // Continuous mod 3; a start during RUN is ignored
      start_cfg(1'b1, 4'd3, 8'd0);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("cont_c%0d", i), 4'(i % 3), (i % 3) == 2, 8'(i / 3), 1, 0, 0);
         start_i = (i == 4); mod_i = 4'd5; cont_i = 1'b0;
         tick();
      end
      start_i = 1'b0;
      chk("cont_still_running", 1, 0, 3, 1, 0, 0);
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      chk("cont_stopped", 0, 0, 0, 0, 0, 0);

      // Hold for 4 cycles at count 5, one-shot mod 10, one wrap
      start_cfg(1'b0, 4'd10, 8'd1);
      for (int j = 0; j < 14; j++) begin
         hold_i = (j >= 5 && j <= 8);
         chk($sformatf("hold_c%0d", j), (j <= 5) ? 4'(j) : ((j <= 9) ? 4'd5 : 4'(j - 4)),
             j == 13, 0, 1, 0, 0);
         tick();
      end
      hold_i = 1'b0;
      chk("hold_done", 0, 0, 1, 0, 1, 0);
      tick();
      chk("hold_idle", 0, 0, 1, 0, 0, 0);

      // Rejected starts keep registers and pulse err for one cycle
      start_cfg(1'b1, 4'd1, 8'd4);
      chk("err_mod1", 0, 0, 1, 0, 0, 1);
      tick();
      chk("err_mod1_clear", 0, 0, 1, 0, 0, 0);
      start_cfg(1'b0, 4'd5, 8'd0);
      chk("err_wraps0", 0, 0, 1, 0, 0, 1);
      tick();
      chk("err_wraps0_clear", 0, 0, 1, 0, 0, 0);

      // Stop landing on the wrap cycle of the second wrap
      start_cfg(1'b0, 4'd4, 8'd3);
      for (int i = 0; i < 7; i++) tick();
      chk("stopwrap_before", 3, 1, 1, 1, 0, 0);
      stop_i = 1'b1;
      chk("stopwrap_tc_forced", 3, 0, 1, 1, 0, 0);
      tick();
      stop_i = 1'b0;
      chk("stopwrap_idle", 0, 0, 0, 0, 0, 0);

      // start and stop together in IDLE
      stop_i = 1'b1;
      start_cfg(1'b0, 4'd6, 8'd1);
      stop_i = 1'b0;
      chk("start_stop_idle", 0, 0, 0, 0, 0, 0);
      tick();
      chk("start_stop_idle2", 0, 0, 0, 0, 0, 0);

      // Reset mid-run at count 7, then a clean short run
      start_cfg(1'b1, 4'd10, 8'd0);
      for (int i = 0; i < 7; i++) tick();
      chk("pre_reset_c7", 7, 0, 0, 1, 0, 0);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("midrun_reset", 0, 0, 0, 0, 0, 0);
      start_cfg(1'b0, 4'd2, 8'd1);
      chk("rerun_c0", 0, 0, 0, 1, 0, 0);
      tick();
      chk("rerun_c1", 1, 1, 0, 1, 0, 0);
      tick();
      chk("rerun_done", 0, 0, 1, 0, 1, 0);
      tick();
      chk("rerun_idle", 0, 0, 1, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
